// File: rtl/fpga_pkg.sv
// Shared constants and types for the ESP32 frame-loading path.
// Frame geometry defaults, sync-word bytes and the loader state encoding.
package fpga_pkg;

    localparam int IMAGE_SIZE = 76800;
    localparam int ADDR_WIDTH = 17;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC1 = 3'd1,
        ST_SYNC2 = 3'd2,
        ST_LOAD  = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop level synchronizer for slow pad inputs crossing into the local clock.
// RESET_VAL lets active-low selects come out of reset in their inactive state.
module cdc_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/frame_loader.sv
// Receives SPI bytes from the ESP32, hunts for the A5 5A sync word and stores one
// frame into the frame buffer, then holds it until the consumer releases it.
module frame_loader #(
    parameter int IMAGE_SIZE = fpga_pkg::IMAGE_SIZE,
    parameter int ADDR_WIDTH = fpga_pkg::ADDR_WIDTH
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  esp_cs_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  buf_release,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);
    import fpga_pkg::*;

    // ADDR_WIDTH must be wide enough that 2**ADDR_WIDTH >= IMAGE_SIZE.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMAGE_SIZE - 1);

    logic                  cs_s;
    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  rx_ready_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [7:0]            wr_data_q;
    logic                  frame_done_q;
    logic                  frame_error_q;
    logic                  busy_q;
    logic [7:0]            drop_cnt_q;

    cdc_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .d_i    (esp_cs_n),
        .q_o    (cs_s)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rx_ready_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            // Pulses default low; rx_ready/busy track the state being entered.
            wr_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            rx_ready_q    <= 1'b1;
            busy_q        <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (!cs_s) state_q <= ST_SYNC1;
                end
                ST_SYNC1: begin
                    if (cs_s) begin
                        state_q <= ST_IDLE;
                    end else if (rx_valid && rx_data == SYNC0) begin
                        state_q <= ST_SYNC2;
                    end
                end
                ST_SYNC2: begin
                    if (cs_s) begin
                        state_q <= ST_IDLE;
                    end else if (rx_valid) begin
                        if (rx_data == SYNC1) begin
                            state_q <= ST_LOAD;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end else if (rx_data != SYNC0) begin
                            state_q <= ST_SYNC1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (rx_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_q;
                        wr_data_q <= rx_data;
                    end
                    // A byte arriving with deselect is stored first; only a short frame errors.
                    if (rx_valid && cnt_q == LAST_ADDR) begin
                        frame_done_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= ST_HOLD;
                        rx_ready_q   <= 1'b0;
                    end else if (cs_s) begin
                        frame_error_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ST_IDLE;
                    end else begin
                        busy_q <= 1'b1;
                        if (rx_valid) cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    end
                end
                ST_HOLD: begin
                    if (buf_release) begin
                        state_q    <= ST_IDLE;
                        drop_cnt_q <= '0;
                    end else begin
                        rx_ready_q <= 1'b0;
                        if (rx_valid && drop_cnt_q != 8'hFF) begin
                            drop_cnt_q <= drop_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_ready    = rx_ready_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader with a 16-byte frame: expected writes are
// queued as bytes are driven and popped when the DUT strobes wr_en.
module tb_frame_loader;

    localparam int IMG = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cs_n = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          buf_release = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_done;
    logic          frame_error;
    logic          busy;
    logic [7:0]    drop_cnt;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          done;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;

    frame_loader #(
        .IMAGE_SIZE (IMG),
        .ADDR_WIDTH (AW)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .esp_cs_n    (cs_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .buf_release (buf_release),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input int a, input int d, input bit last);
        wr_exp_t e;
        e.addr = AW'(a);
        e.data = 8'(d);
        e.done = last;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; leaves the bench at the following posedge+1.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_buf();
        buf_release = 1'b1;
        idle(1);
        buf_release = 1'b0;
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_en_unexp", 32'(wr_en), 32'(0));
            end else begin
                wr_exp_t e;
                e = exp_q.pop_front();
                $display("write addr=%0d data=%02h done=%0b", wr_addr, wr_data, frame_done);
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
                check("wr_done", 32'(frame_done), 32'(e.done));
            end
        end else if (frame_done) begin
            check("done_wo_wr", 32'(frame_done), 32'(0));
        end
        if (frame_done || frame_error) check("done_err_excl", 32'(frame_done & frame_error), 32'(0));
        if (frame_done)  done_cnt++;
        if (frame_error) err_cnt++;
    end

    initial begin
        #2 rst_n = 1'b0;
        idle(3);
        check("rst_rdy",   32'(rx_ready), 32'(0));
        check("rst_wr_en", 32'(wr_en),    32'(0));
        check("rst_busy",  32'(busy),     32'(0));
        check("rst_drop",  32'(drop_cnt), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_before_edge", 32'(rx_ready), 32'(0));
        @(posedge clk);
        #1;
        check("rdy_after_edge", 32'(rx_ready), 32'(1));

        // Full frame 00..0F.
        cs_n = 1'b0;
        idle(4);
        send(8'hA5);
        send(8'h5A);
        check("busy_load", 32'(busy), 32'(1));
        for (int i = 0; i < IMG; i++) begin
            push_wr(i, i, i == IMG - 1);
            send(8'(i));
        end
        idle(3);
        check("f1_q_empty", 32'(exp_q.size()), 32'(0));
        check("f1_done",    32'(done_cnt), 32'(1));
        check("f1_err",     32'(err_cnt),  32'(0));
        check("hold_rdy",   32'(rx_ready), 32'(0));
        check("hold_busy",  32'(busy),     32'(0));

        // Drops in HOLD saturate, release clears.
        for (int i = 0; i < 300; i++) send(8'h33);
        idle(2);
        check("drop_sat", 32'(drop_cnt), 32'(255));
        release_buf();
        check("drop_clr", 32'(drop_cnt), 32'(0));
        check("rel_rdy",  32'(rx_ready), 32'(1));

        // Garbage and repeated A5 before sync, then abort after 5 bytes.
        idle(2);
        send(8'h11);
        send(8'hA5);
        send(8'hA5);
        send(8'h5A);
        push_wr(0, 8'h77, 1'b0);
        send(8'h77);
        for (int i = 1; i < 5; i++) begin
            push_wr(i, i, 1'b0);
            send(8'(i));
        end
        cs_n = 1'b1;
        idle(6);
        check("abort_err",  32'(err_cnt),  32'(1));
        check("abort_done", 32'(done_cnt), 32'(1));
        check("abort_busy", 32'(busy),     32'(0));
        send(8'h99);
        idle(2);
        check("abort_q_empty", 32'(exp_q.size()), 32'(0));

        // Final byte coincides with synchronized deselect.
        cs_n = 1'b0;
        idle(4);
        send(8'hA5);
        send(8'h5A);
        for (int i = 0; i < IMG; i++) begin
            push_wr(i, 8'hC0 + i, i == IMG - 1);
            if (i == IMG - 3) cs_n = 1'b1;
            send(8'(8'hC0 + i));
        end
        idle(3);
        check("coinc_done", 32'(done_cnt), 32'(2));
        check("coinc_err",  32'(err_cnt),  32'(1));
        check("coinc_rdy",  32'(rx_ready), 32'(0));
        release_buf();

        // Reset in the middle of a frame.
        cs_n = 1'b0;
        idle(4);
        send(8'hA5);
        send(8'h5A);
        for (int i = 0; i < 8; i++) begin
            push_wr(i, 8'h40 + i, 1'b0);
            send(8'(8'h40 + i));
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_wr_en", 32'(wr_en),       32'(0));
        check("mrst_addr",  32'(wr_addr),     32'(0));
        check("mrst_data",  32'(wr_data),     32'(0));
        check("mrst_rdy",   32'(rx_ready),    32'(0));
        check("mrst_busy",  32'(busy),        32'(0));
        check("mrst_done",  32'(frame_done),  32'(0));
        check("mrst_err",   32'(frame_error), 32'(0));
        idle(3);
        rst_n = 1'b1;
        idle(3);
        check("mrst_done_cnt", 32'(done_cnt), 32'(2));
        check("mrst_err_cnt",  32'(err_cnt),  32'(1));
        check("end_q_empty",   32'(exp_q.size()), 32'(0));
        check("end_rdy",       32'(rx_ready), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
